diff_eq_sequencer: RTL and testbench
====================================

DIFF_EQ_SEQUENCER -- requirements
Module: diff_eq_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: signed sample width of x_in and y_out.
REQ-002 Parameter COEF_W, default 18: signed coefficient width.
REQ-003 Parameter FRAC_W, default 16: coefficient fraction bits; 1.0 = 2^FRAC_W.
REQ-004 Parameter ACC_W, default 40: signed accumulator width.
REQ-005 Ports, one per line:
- ACLK  in  1  sole clock, rising edge.
- ARESET  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to evaluate one sample.
- clear_state  in  1  zeroes history and aborts any evaluation.
- x_in  in  DATA_W  new sample, sampled with start.
- b0, b1, b2, a1, a2  in  COEF_W each  coefficients, sampled with start.
- y_out  out  DATA_W  latest result.
- done  out  1  one-cycle pulse when y_out updates.
- busy  out  1  evaluation in progress.
- sat  out  1  last result was clipped.
- overrun  out  1  sticky flag: a start arrived while busy.

Function
REQ-006 The block SHALL compute y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2] using one shared multiplier, one tap per cycle.
REQ-007 FSM states SHALL be IDLE, MAC, OUT. IDLE->MAC on start. MAC->OUT after the fifth tap. OUT->IDLE unconditionally.
REQ-008 A start accepted at edge k SHALL latch x_in and all five coefficients into shadow registers; later input changes SHALL NOT affect that evaluation.
REQ-009 Taps SHALL accumulate at edges k+1..k+5, in order b0, b1, b2, a1, a2.
REQ-010 At edge k+6 the block SHALL register y_out, shift history (x[n-2]<=x[n-1]<=x[n], y[n-2]<=y[n-1]<=y_out), assert done for exactly one cycle and deassert busy.
REQ-011 busy SHALL be high from edge k+1 through edge k+6 exclusive. Start-to-done latency SHALL be 6 cycles. A back-to-back start is accepted in the cycle done is high.
REQ-012 Products SHALL be full precision (DATA_W+COEF_W), sign-extended to ACC_W. Accumulation SHALL wrap modulo 2^ACC_W.
REQ-013 Rounding: add 2^(FRAC_W-1) to the accumulator, then arithmetic-shift right by FRAC_W.
REQ-014 A start while busy SHALL be ignored and SHALL set overrun. overrun clears only on ARESET or clear_state.
REQ-015 clear_state SHALL zero x/y history, accumulator, sat and overrun. An evaluation in progress SHALL abort: FSM goes to IDLE next edge, no done, y_out retains its value.
REQ-016 clear_state together with start SHALL drop the start.

Reset
REQ-017 On ARESET: FSM=IDLE, y_out=0, done=0, busy=0, sat=0, overrun=0, history and accumulator zero. ARESET SHALL override every other input.

Configuration
REQ-018 With macro DIFF_EQ_SEQ_SAT_EN defined: the rounded result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and sat SHALL be set when clipping occurs and updated at every done.
REQ-019 Without the macro: the result SHALL truncate to the low DATA_W bits (two's-complement wrap), and sat SHALL be tied 0.

Structure
REQ-020 Package diff_eq_pkg SHALL hold the FSM state enum, the default widths and the tap-index constants.
REQ-021 Multiply-accumulate SHALL be sub-module diff_eq_mac (inputs: operand, coefficient, subtract, clear, enable; output: accumulator). All sequencing SHALL stay in diff_eq_sequencer.

Verification
REQ-022 Identity: b0=0x10000, other coefficients 0, start with x_in=1000 -> done exactly 6 cycles later, y_out=1000, busy high 5 cycles.
REQ-023 First-order IIR: b0=0x08000, a1=0x38000 (-0.5), others 0; inputs x=1000, 0, 0 -> y_out=500, 250, 125.
REQ-024 Overflow: b0=0x18000 (1.5), x_in=30000 -> with DIFF_EQ_SEQ_SAT_EN, y_out=32767 and sat=1; without it, y_out=-20536 and sat=0.
REQ-025 Overrun: start at cycle k and again at k+2 -> single done at k+6, overrun=1 until clear_state.
REQ-026 Abort: clear_state at k+3 -> no done, busy low after k+4, next identity evaluation with x_in=7 -> y_out=7 with zero history.
REQ-027 Reset mid-evaluation: ARESET at k+2 -> all outputs 0 next edge, no done pulse.

Source files
------------

// File: rtl/diff_eq_pkg.sv
// Shared types and constants for the second-order difference-equation sequencer.
package diff_eq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 18;
  localparam int FRAC_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  // Feedback taps (a1, a2) enter the accumulator with a negative sign.
  function automatic logic tap_is_feedback(input logic [2:0] tap);
    return tap >= TAP_A1;
  endfunction

endpackage

// File: rtl/diff_eq_mac.sv
// Shared signed multiply-accumulate: one full-precision product per enabled cycle,
// added to or subtracted from a wrapping accumulator.
module diff_eq_mac
  import diff_eq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [DATA_W-1:0] operand,
  input  logic [COEF_W-1:0] coef,
  input  logic              subtract,
  input  logic              clear,
  input  logic              enable,
  output logic [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         acc_d;
  logic [ACC_W-1:0]         acc_q;

  always_comb begin
    prod     = PROD_W'($signed(operand)) * PROD_W'($signed(coef));
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_d    = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = subtract ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/diff_eq_sequencer.sv
// Biquad difference-equation evaluator, one tap per cycle on a shared MAC.
// Define DIFF_EQ_SEQ_SAT_EN to saturate the output (and report sat); otherwise it wraps.
//
// state   | meaning
// ST_IDLE | waiting for start; shadows hold the last accepted request
// ST_MAC  | accumulating taps b0, b1, b2, a1, a2 (one per cycle)
// ST_OUT  | round/limit accumulator, publish y_out, shift history
module diff_eq_sequencer
  import diff_eq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              clear_state,
  input  logic [DATA_W-1:0] x_in,
  input  logic [COEF_W-1:0] b0,
  input  logic [COEF_W-1:0] b1,
  input  logic [COEF_W-1:0] b2,
  input  logic [COEF_W-1:0] a1,
  input  logic [COEF_W-1:0] a2,
  output logic [DATA_W-1:0] y_out,
  output logic              done,
  output logic              busy,
  output logic              sat,
  output logic              overrun
);

  localparam logic [ACC_W-1:0] RND = {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          tap_q, tap_d;
  logic [DATA_W-1:0]   x_sh_q, x_sh_d;
  logic [COEF_W-1:0]   b0_sh_q, b0_sh_d;
  logic [COEF_W-1:0]   b1_sh_q, b1_sh_d;
  logic [COEF_W-1:0]   b2_sh_q, b2_sh_d;
  logic [COEF_W-1:0]   a1_sh_q, a1_sh_d;
  logic [COEF_W-1:0]   a2_sh_q, a2_sh_d;
  logic [DATA_W-1:0]   x1_q, x1_d;
  logic [DATA_W-1:0]   x2_q, x2_d;
  logic [DATA_W-1:0]   y1_q, y1_d;
  logic [DATA_W-1:0]   y2_q, y2_d;
  logic [DATA_W-1:0]   y_out_q, y_out_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                sat_q, sat_d;
  logic                overrun_q, overrun_d;

  logic [DATA_W-1:0]   mac_op;
  logic [COEF_W-1:0]   mac_coef;
  logic                mac_sub;
  logic                mac_clear;
  logic                mac_en;
  logic [ACC_W-1:0]    mac_acc;
  logic [ACC_W-1:0]    acc_rnd;
  logic [DATA_W-1:0]   y_res;
  logic                sat_res;
  logic                unused_rnd;

  diff_eq_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .operand  (mac_op),
    .coef     (mac_coef),
    .subtract (mac_sub),
    .clear    (mac_clear),
    .enable   (mac_en),
    .acc      (mac_acc)
  );

  always_comb begin
    mac_op   = y2_q;
    mac_coef = a2_sh_q;
    case (tap_q)
      TAP_B0: begin mac_op = x_sh_q; mac_coef = b0_sh_q; end
      TAP_B1: begin mac_op = x1_q;   mac_coef = b1_sh_q; end
      TAP_B2: begin mac_op = x2_q;   mac_coef = b2_sh_q; end
      TAP_A1: begin mac_op = y1_q;   mac_coef = a1_sh_q; end
      default: begin mac_op = y2_q;  mac_coef = a2_sh_q; end
    endcase
    mac_sub = tap_is_feedback(tap_q);
  end

  // Rounded value is acc_rnd >>> FRAC_W; its low DATA_W bits are the FRAC_W-offset slice.
  assign acc_rnd    = mac_acc + RND;
  assign unused_rnd = ^acc_rnd;

  always_comb begin
    y_res   = acc_rnd[FRAC_W +: DATA_W];
    sat_res = 1'b0;
`ifdef DIFF_EQ_SEQ_SAT_EN
    if (!((&acc_rnd[ACC_W-1:FRAC_W+DATA_W-1]) || !(|acc_rnd[ACC_W-1:FRAC_W+DATA_W-1]))) begin
      sat_res = 1'b1;
      y_res   = acc_rnd[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    x_sh_d    = x_sh_q;
    b0_sh_d   = b0_sh_q;
    b1_sh_d   = b1_sh_q;
    b2_sh_d   = b2_sh_q;
    a1_sh_d   = a1_sh_q;
    a2_sh_d   = a2_sh_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    y_out_d   = y_out_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    sat_d     = sat_q;
    overrun_d = overrun_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !clear_state) begin
          x_sh_d    = x_in;
          b0_sh_d   = b0;
          b1_sh_d   = b1;
          b2_sh_d   = b2;
          a1_sh_d   = a1;
          a2_sh_d   = a2;
          tap_d     = TAP_B0;
          mac_clear = 1'b1;
          state_d   = ST_MAC;
        end
      end
      ST_MAC: begin
        busy_d = 1'b1;
        mac_en = 1'b1;
        tap_d  = tap_q + 3'd1;
        if (tap_q == TAP_A2) begin
          tap_d   = TAP_B0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        y_out_d = y_res;
        sat_d   = sat_res;
        done_d  = 1'b1;
        x2_d    = x1_q;
        x1_d    = x_sh_q;
        y2_d    = y1_q;
        y1_d    = y_res;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    // Abort: history is wiped but the last published y_out stays visible.
    if (clear_state) begin
      state_d   = ST_IDLE;
      tap_d     = TAP_B0;
      x1_d      = '0;
      x2_d      = '0;
      y1_d      = '0;
      y2_d      = '0;
      y_out_d   = y_out_q;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      sat_d     = 1'b0;
      overrun_d = 1'b0;
      mac_clear = 1'b1;
      mac_en    = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      tap_q     <= TAP_B0;
      x_sh_q    <= '0;
      b0_sh_q   <= '0;
      b1_sh_q   <= '0;
      b2_sh_q   <= '0;
      a1_sh_q   <= '0;
      a2_sh_q   <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      y_out_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      x_sh_q    <= x_sh_d;
      b0_sh_q   <= b0_sh_d;
      b1_sh_q   <= b1_sh_d;
      b2_sh_q   <= b2_sh_d;
      a1_sh_q   <= a1_sh_d;
      a2_sh_q   <= a2_sh_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      y_out_q   <= y_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign y_out   = y_out_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign sat     = sat_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_diff_eq_sequencer.sv
// Directed bench for diff_eq_sequencer: arithmetic reference model plus literal checks.
module tb_diff_eq_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic        clear_state;
  logic [15:0] x_in;
  logic [17:0] b0, b1, b2, a1, a2;
  logic [15:0] y_out;
  logic        done, busy, sat, overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  diff_eq_sequencer dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .start       (start),
    .clear_state (clear_state),
    .x_in        (x_in),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2),
    .y_out       (y_out),
    .done        (done),
    .busy        (busy),
    .sat         (sat),
    .overrun     (overrun)
  );

  always #5 ACLK = ~ACLK;

  function automatic longint wrap(input longint v, input int w);
    int sh = 64 - w;
    return (v <<< sh) >>> sh;
  endfunction

  function automatic longint sy(input logic [15:0] v);
    return wrap(longint'(v), 16);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts cycles since acceptance and evaluates the equation in integers.
  longint cx, cb0, cb1, cb2, ca1, ca2;
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  longint m_acc, m_r;
  bit     m_act = 0;
  int     m_age = 0;
  longint exp_y = 0;
  bit     exp_done = 0, exp_busy = 0, exp_sat = 0, exp_ovr = 0;

  always @(posedge ACLK) begin
    exp_done = 0;
    if (ARESET) begin
      m_act = 0; mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      exp_y = 0; exp_busy = 0; exp_sat = 0; exp_ovr = 0;
    end else if (clear_state) begin
      m_act = 0; mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      exp_busy = 0; exp_sat = 0; exp_ovr = 0;
    end else if (m_act) begin
      if (start) exp_ovr = 1;
      m_age++;
      exp_busy = (m_age <= 5);
      if (m_age == 6) begin
        m_acc = wrap(cb0*cx + cb1*mx1 + cb2*mx2 - ca1*my1 - ca2*my2, 40);
        m_r   = wrap(m_acc + 32768, 40) >>> 16;
`ifdef DIFF_EQ_SEQ_SAT_EN
        if (m_r > 32767) begin exp_y = 32767; exp_sat = 1; end
        else if (m_r < -32768) begin exp_y = -32768; exp_sat = 1; end
        else begin exp_y = m_r; exp_sat = 0; end
`else
        exp_y = wrap(m_r, 16);
        exp_sat = 0;
`endif
        mx2 = mx1; mx1 = cx; my2 = my1; my1 = exp_y;
        exp_done = 1;
        m_act = 0;
      end
    end else if (start) begin
      m_act = 1; m_age = 0;
      cx  = wrap(longint'(x_in), 16);
      cb0 = wrap(longint'(b0), 18); cb1 = wrap(longint'(b1), 18);
      cb2 = wrap(longint'(b2), 18); ca1 = wrap(longint'(a1), 18);
      ca2 = wrap(longint'(a2), 18);
    end
  end

  always @(posedge ACLK) begin
    #1;
    if (done) n_done++;
    chk("done", done, exp_done);
    chk("busy", busy, exp_busy);
    chk("sat", sat, exp_sat);
    chk("overrun", overrun, exp_ovr);
    chk("y_out", sy(y_out), exp_y);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_coef(input logic [17:0] c0, c1, c2, c3, c4);
    b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
  endtask

  task automatic pulse_clear();
    @(negedge ACLK); clear_state = 1;
    @(negedge ACLK); clear_state = 0;
  endtask

  // Start one evaluation, scramble inputs while it runs, report done offset and busy cycles.
  task automatic eval(input logic [15:0] x, output int d_at, output int b_cnt);
    logic [17:0] s0, s1, s2, s3, s4;
    @(negedge ACLK); x_in = x; start = 1;
    @(negedge ACLK); start = 0;
    s0 = b0; s1 = b1; s2 = b2; s3 = a1; s4 = a2;
    x_in = 16'($urandom);
    set_coef(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    d_at = -1; b_cnt = 0;
    for (int j = 1; j <= 8; j++) begin
      @(posedge ACLK); #1;
      if (done) d_at = j;
      if (busy) b_cnt++;
    end
    set_coef(s0, s1, s2, s3, s4);
  endtask

  int d_at, b_cnt, nd0;

  initial begin
    ARESET = 1; start = 0; clear_state = 0; x_in = 0;
    set_coef(0, 0, 0, 0, 0);
    repeat (3) @(negedge ACLK);
    chk("rst_y", sy(y_out), 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovr", overrun, 0);
    ARESET = 0;

    set_coef(18'h10000, 0, 0, 0, 0);
    eval(16'd1000, d_at, b_cnt);
    chk("id_latency", d_at, 6);
    chk("id_busy_cycles", b_cnt, 5);
    chk("id_y", sy(y_out), 1000);

    pulse_clear();
    set_coef(18'h08000, 0, 0, 18'h38000, 0);
    eval(16'd1000, d_at, b_cnt); chk("iir_y0", sy(y_out), 500);
    eval(16'd0, d_at, b_cnt);    chk("iir_y1", sy(y_out), 250);
    eval(16'd0, d_at, b_cnt);    chk("iir_y2", sy(y_out), 125);

    pulse_clear();
    set_coef(18'h18000, 0, 0, 0, 0);
    eval(16'd30000, d_at, b_cnt);
`ifdef DIFF_EQ_SEQ_SAT_EN
    chk("ovf_y", sy(y_out), 32767);
    chk("ovf_sat", sat, 1);
`else
    chk("ovf_y", sy(y_out), -20536);
    chk("ovf_sat", sat, 0);
`endif
    pulse_clear();
    chk("clr_sat", sat, 0);

    set_coef(18'h0C000, 0, 0, 0, 0);
    eval(16'hFFFD, d_at, b_cnt);
    chk("round_neg", sy(y_out), -2);

    // Back-to-back start in the done cycle.
    set_coef(18'h10000, 0, 0, 0, 0);
    @(negedge ACLK); x_in = 16'd10; start = 1;
    @(negedge ACLK); start = 0;
    repeat (6) @(negedge ACLK);
    chk("b2b_done_hi", done, 1);
    chk("b2b_first_y", sy(y_out), 10);
    x_in = 16'd20; start = 1;
    @(negedge ACLK); start = 0;
    repeat (8) @(negedge ACLK);
    chk("b2b_second_y", sy(y_out), 20);
    chk("b2b_no_ovr", overrun, 0);

    // Second start two cycles after acceptance.
    nd0 = n_done;
    @(negedge ACLK); x_in = 16'd5; start = 1;
    @(negedge ACLK); start = 0;
    @(negedge ACLK); x_in = 16'd9; start = 1;
    @(negedge ACLK); start = 0;
    repeat (10) @(negedge ACLK);
    chk("ovr_done_count", n_done - nd0, 1);
    chk("ovr_y", sy(y_out), 5);
    chk("ovr_flag", overrun, 1);
    repeat (3) @(negedge ACLK);
    chk("ovr_sticky", overrun, 1);
    pulse_clear();
    chk("ovr_cleared", overrun, 0);

    // Abort mid-evaluation; b1 makes stale history visible.
    set_coef(18'h10000, 18'h10000, 0, 0, 0);
    eval(16'd100, d_at, b_cnt);
    chk("abort_pre_y", sy(y_out), 100);
    nd0 = n_done;
    @(negedge ACLK); x_in = 16'd50; start = 1;
    @(negedge ACLK); start = 0;
    @(negedge ACLK);
    @(negedge ACLK); clear_state = 1;
    @(negedge ACLK); clear_state = 0;
    chk("abort_busy", busy, 0);
    repeat (8) @(negedge ACLK);
    chk("abort_no_done", n_done - nd0, 0);
    chk("abort_y_kept", sy(y_out), 100);
    eval(16'd7, d_at, b_cnt);
    chk("abort_next_y", sy(y_out), 7);

    // Reset mid-evaluation.
    nd0 = n_done;
    @(negedge ACLK); x_in = 16'd1234; start = 1;
    @(negedge ACLK); start = 0;
    @(negedge ACLK); ARESET = 1;
    @(negedge ACLK); ARESET = 0;
    chk("rstmid_y", sy(y_out), 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    repeat (8) @(negedge ACLK);
    chk("rstmid_no_done", n_done - nd0, 0);

    repeat (2) @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
